// File: rtl/dual_port_mem_responder_pkg.sv
// rtl/dual_port_mem_responder_pkg.sv - shared types and helpers for the dual-port memory responder
package dual_port_mem_responder_pkg;

    localparam int unsigned WORD_WIDTH = 32;
    localparam int unsigned CNT_WIDTH  = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } port_state_e;

    typedef enum logic {
        PORT_IMEM = 1'b0,
        PORT_DMEM = 1'b1
    } port_id_e;

    function automatic logic [WORD_WIDTH-1:0] merge_bytes(
        input logic [WORD_WIDTH-1:0] old_word,
        input logic [WORD_WIDTH-1:0] new_word,
        input logic [3:0]            we
    );
        logic [WORD_WIDTH-1:0] merged;
        for (int i = 0; i < 4; i++) begin
            merged[8*i +: 8] = we[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/dual_port_mem_responder_port_fsm.sv
// rtl/dual_port_mem_responder_port_fsm.sv - per-port IDLE/WAIT/RESP sequencer with latency counter
module dual_port_mem_responder_port_fsm
    import dual_port_mem_responder_pkg::*;
#(
    parameter int unsigned LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  grant_i,
    input  logic [WORD_WIDTH-1:0] acc_rdata_i,
    input  logic                  acc_err_i,
    output logic                  idle_o,
    output logic                  ready_o,
    output logic [WORD_WIDTH-1:0] rdata_o,
    output logic                  err_o
);

    localparam logic [CNT_WIDTH-1:0] CNT_LOAD = CNT_WIDTH'(LATENCY - 1);

    port_state_e           state_q, state_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [WORD_WIDTH-1:0] hold_rdata_q, hold_rdata_d;
    logic                  hold_err_q, hold_err_d;
    logic [WORD_WIDTH-1:0] rdata_q, rdata_d;
    logic                  err_q, err_d;

    // Access result is parked in hold_* so rdata_o only changes on entry to RESP.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        hold_rdata_d = hold_rdata_q;
        hold_err_d   = hold_err_q;
        rdata_d      = rdata_q;
        err_d        = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (grant_i) begin
                    hold_rdata_d = acc_rdata_i;
                    hold_err_d   = acc_err_i;
                    cnt_d        = CNT_LOAD;
                    if (LATENCY == 1) begin
                        state_d = ST_RESP;
                        rdata_d = acc_rdata_i;
                        err_d   = acc_err_i;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == CNT_WIDTH'(1)) begin
                    state_d = ST_RESP;
                    rdata_d = hold_rdata_q;
                    err_d   = hold_err_q;
                end else begin
                    cnt_d = cnt_q - CNT_WIDTH'(1);
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            hold_rdata_q <= '0;
            hold_err_q   <= 1'b0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            hold_rdata_q <= hold_rdata_d;
            hold_err_q   <= hold_err_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
        end
    end

    assign idle_o  = (state_q == ST_IDLE);
    assign ready_o = (state_q == ST_RESP);
    assign rdata_o = rdata_q;
    assign err_o   = err_q;

endmodule

// File: rtl/dual_port_mem_responder.sv
// rtl/dual_port_mem_responder.sv - imem/dmem responder sharing one single-port word array
module dual_port_mem_responder
    import dual_port_mem_responder_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           MEM_WORDS  = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter int unsigned           LATENCY    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  imem_valid_i,
    output logic                  imem_ready_o,
    input  logic [ADDR_WIDTH-1:0] imem_addr_i,
    input  logic [WORD_WIDTH-1:0] imem_wdata_i,
    input  logic [3:0]            imem_we_i,
    output logic [WORD_WIDTH-1:0] imem_rdata_o,
    output logic                  imem_err_o,
    input  logic                  dmem_valid_i,
    output logic                  dmem_ready_o,
    input  logic [ADDR_WIDTH-1:0] dmem_addr_i,
    input  logic [WORD_WIDTH-1:0] dmem_wdata_i,
    input  logic [3:0]            dmem_we_i,
    output logic [WORD_WIDTH-1:0] dmem_rdata_o,
    output logic                  dmem_err_o
);

    localparam int unsigned IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    // One extra bit so the upper bound cannot wrap at the top of the address space.
    localparam logic [ADDR_WIDTH:0] LIMIT = {1'b0, BASE_ADDR} + (ADDR_WIDTH+1)'(4 * MEM_WORDS);

    logic [WORD_WIDTH-1:0] mem [MEM_WORDS];

    port_id_e              rr_last_q, rr_last_d;
    logic                  imem_idle, dmem_idle;
    logic                  imem_req, dmem_req, imem_grant, dmem_grant, any_grant;
    logic [ADDR_WIDTH-1:0] acc_addr, acc_off;
    logic [WORD_WIDTH-1:0] acc_wdata, acc_rdata;
    logic [3:0]            acc_we;
    logic                  acc_in_range, acc_err;
    logic [IDX_W-1:0]      acc_idx;

    always_comb begin
        imem_req   = imem_valid_i & imem_idle & ~rst;
        dmem_req   = dmem_valid_i & dmem_idle & ~rst;
        imem_grant = imem_req & (~dmem_req | (rr_last_q == PORT_DMEM));
        dmem_grant = dmem_req & (~imem_req | (rr_last_q == PORT_IMEM));
        any_grant  = imem_grant | dmem_grant;

        rr_last_d = rr_last_q;
        if (imem_grant) begin
            rr_last_d = PORT_IMEM;
        end else if (dmem_grant) begin
            rr_last_d = PORT_DMEM;
        end

        acc_addr     = dmem_grant ? dmem_addr_i  : imem_addr_i;
        acc_wdata    = dmem_grant ? dmem_wdata_i : imem_wdata_i;
        acc_we       = dmem_grant ? dmem_we_i    : imem_we_i;
        acc_off      = acc_addr - BASE_ADDR;
        acc_idx      = IDX_W'(acc_off >> 2);
        acc_in_range = ({1'b0, acc_addr} >= {1'b0, BASE_ADDR}) && ({1'b0, acc_addr} < LIMIT);
        acc_err      = ~acc_in_range;
        acc_rdata    = acc_in_range ? mem[acc_idx] : '0;
    end

    always_ff @(posedge clk) begin
        if (any_grant && acc_in_range && (acc_we != 4'b0000)) begin
            mem[acc_idx] <= merge_bytes(mem[acc_idx], acc_wdata, acc_we);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_last_q <= PORT_IMEM;
        end else begin
            rr_last_q <= rr_last_d;
        end
    end

    dual_port_mem_responder_port_fsm #(.LATENCY(LATENCY)) u_imem_fsm (
        .clk         (clk),
        .rst         (rst),
        .grant_i     (imem_grant),
        .acc_rdata_i (acc_rdata),
        .acc_err_i   (acc_err),
        .idle_o      (imem_idle),
        .ready_o     (imem_ready_o),
        .rdata_o     (imem_rdata_o),
        .err_o       (imem_err_o)
    );

    dual_port_mem_responder_port_fsm #(.LATENCY(LATENCY)) u_dmem_fsm (
        .clk         (clk),
        .rst         (rst),
        .grant_i     (dmem_grant),
        .acc_rdata_i (acc_rdata),
        .acc_err_i   (acc_err),
        .idle_o      (dmem_idle),
        .ready_o     (dmem_ready_o),
        .rdata_o     (dmem_rdata_o),
        .err_o       (dmem_err_o)
    );

endmodule
